// File: rtl/fwd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_pkg : shared select codes and pipeline stage-entry type            |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  localparam logic [1:0] FWD_IMM   = 2'd3;

  // Register-address width the stage entry is sized for; the top's REG_AW must match it.
  localparam int unsigned FWD_REG_AW = 5;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } stage_entry_t;

  localparam stage_entry_t STAGE_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/fwd_src_cmp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_src_cmp : priority compare of one source register against EX/MEM  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              e_valid,
  input  logic              e_regwrite,
  input  logic [REG_AW-1:0] e_dest,
  input  logic              m_valid,
  input  logic              m_regwrite,
  input  logic [REG_AW-1:0] m_dest,
  output logic [1:0]        sel
);

  // The younger producer (in EX) shadows the older one; r0 is hardwired so never forwards.
  always_comb begin
    sel = FWD_RF;
    if (e_valid && e_regwrite && (e_dest != '0) && (e_dest == src)) begin
      sel = FWD_EXMEM;
    end else if (m_valid && m_regwrite && (m_dest != '0) && (m_dest == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_sel_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_sel_ctrl : ALU operand forwarding selects and load-use stall       |
// | Optional stall counter enabled by macro FWD_STALL_CNT_EN.              |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module fwd_sel_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_use_imm,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_entry_t e_q, e_d;
  stage_entry_t m_q, m_d;
  logic [1:0]   fwd_a_q, fwd_a_d;
  logic [1:0]   fwd_b_q, fwd_b_d;
  logic [1:0]   sel_a, sel_b;
  logic         load_use;
  logic         issue;

  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .src        (id_rs),
    .e_valid    (e_q.valid),
    .e_regwrite (e_q.regwrite),
    .e_dest     (e_q.dest),
    .m_valid    (m_q.valid),
    .m_regwrite (m_q.regwrite),
    .m_dest     (m_q.dest),
    .sel        (sel_a)
  );

  fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .src        (id_rt),
    .e_valid    (e_q.valid),
    .e_regwrite (e_q.regwrite),
    .e_dest     (e_q.dest),
    .m_valid    (m_q.valid),
    .m_regwrite (m_q.regwrite),
    .m_dest     (m_q.dest),
    .sel        (sel_b)
  );

  always_comb begin
    load_use = e_q.valid && e_q.memread && (e_q.dest != '0) &&
               ((e_q.dest == id_rs) || (id_uses_rt && (e_q.dest == id_rt)));
    // A flush kills the ID instruction, so it can never be the victim of a hazard.
    stall    = id_valid && !flush && load_use;
    issue    = id_valid && !stall && !flush;
  end

  always_comb begin
    m_d     = e_q;
    e_d     = STAGE_BUBBLE;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (issue) begin
      e_d.valid    = 1'b1;
      e_d.dest     = id_dest;
      e_d.regwrite = id_regwrite;
      e_d.memread  = id_memread;
      fwd_a_d      = sel_a;
      fwd_b_d      = id_use_imm ? FWD_IMM : sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= STAGE_BUBBLE;
      m_q     <= STAGE_BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

  // The MEM entry keeps its load flag for debug visibility only.
  logic unused_m_memread;
  assign unused_m_memread = m_q.memread;

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fwd_sel_ctrl : directed table, reset sequences and random stimulus  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_fwd_sel_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_uses_rt, id_use_imm, id_regwrite, id_memread, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_use_imm  (id_use_imm),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       imm;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       es;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  // Reference model: the most recently issued instructions, youngest first.
  typedef struct {
    bit valid;
    int dest;
    bit rw;
    bit mr;
  } slot_t;

  slot_t hist[$];
  int    m_stall_total;
  bit    m_stall;
  int    m_a, m_b;

  function automatic int youngest_writer(int src);
    for (int age = 0; age < hist.size() && age < 2; age++) begin
      if (hist[age].valid && hist[age].rw && hist[age].dest != 0 && hist[age].dest == src)
        return age + 1;
    end
    return 0;
  endfunction

  function automatic int exp_cnt();
`ifdef FWD_STALL_CNT_EN
    return m_stall_total;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    m_stall_total = 0;
  endtask

  task automatic model_step(input vec_t v);
    slot_t s;
    bit    hz;
    hz = 1'b0;
    if (hist.size() > 0)
      hz = hist[0].valid && hist[0].mr && hist[0].dest != 0 &&
           (hist[0].dest == int'(v.rs) || (v.urt && hist[0].dest == int'(v.rt)));
    m_stall = v.v && !v.fl && hz;
    s = '{valid: 1'b0, dest: 0, rw: 1'b0, mr: 1'b0};
    m_a = 0;
    m_b = 0;
    if (v.v && !v.fl && !m_stall) begin
      s    = '{valid: 1'b1, dest: int'(v.dest), rw: v.rw, mr: v.mr};
      m_a  = youngest_writer(int'(v.rs));
      m_b  = v.imm ? 3 : youngest_writer(int'(v.rt));
    end
    if (m_stall) m_stall_total++;
    hist.push_front(s);
    if (hist.size() > 2) void'(hist.pop_back());
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid    = v.v;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_uses_rt  = v.urt;
    id_use_imm  = v.imm;
    id_dest     = v.dest;
    id_regwrite = v.rw;
    id_memread  = v.mr;
    flush       = v.fl;
  endtask

  // One pipeline cycle: stall sampled mid-cycle, selects sampled just after the edge.
  task automatic apply(input vec_t v, output logic o_stall, output logic [1:0] o_a,
                       output logic [1:0] o_b, output int o_cnt);
    drive(v);
    model_step(v);
    @(negedge clk);
    o_stall = stall;
    @(posedge clk);
    #1;
    o_a   = fwd_a;
    o_b   = fwd_b;
    o_cnt = int'(stall_cnt);
  endtask

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urt, logic imm,
                              logic [4:0] dest, logic rw, logic mr, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb);
    vec_t r;
    r = '{v: v, rs: rs, rt: rt, urt: urt, imm: imm, dest: dest, rw: rw, mr: mr, fl: fl,
          es: es, ea: ea, eb: eb};
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    logic       s_o;
    logic [1:0] a_o, b_o;
    int         c_o;
    vec_t       rv;

    //            v  rs  rt urt imm dest rw mr fl   es ea eb
    tbl[0]  = mk(1,  1,  2, 1, 0,  3,  1, 0, 0,   0, 0, 0); // add r3
    tbl[1]  = mk(1,  3,  4, 1, 0,  9,  1, 0, 0,   0, 1, 0); // consumer of r3
    tbl[2]  = mk(1,  0,  0, 1, 0,  5,  1, 0, 0,   0, 0, 0); // producer r5
    tbl[3]  = mk(1,  1,  2, 1, 0,  6,  1, 0, 0,   0, 0, 0); // unrelated
    tbl[4]  = mk(1, 10,  5, 1, 0, 11,  0, 0, 0,   0, 0, 2); // distance-2 on rt
    tbl[5]  = mk(1,  0,  0, 1, 0,  7,  1, 0, 0,   0, 0, 0); // r7 old
    tbl[6]  = mk(1,  0,  0, 1, 0,  7,  1, 0, 0,   0, 0, 0); // r7 young
    tbl[7]  = mk(1,  7,  7, 1, 0, 12,  0, 0, 0,   0, 1, 1); // youngest wins, both sources
    tbl[8]  = mk(1,  0,  0, 1, 0,  8,  1, 1, 0,   0, 0, 0); // load r8
    tbl[9]  = mk(1,  8,  1, 1, 0, 13,  1, 0, 0,   1, 0, 0); // load-use stall, bubble
    tbl[10] = mk(1,  8,  1, 1, 0, 13,  1, 0, 0,   0, 2, 0); // replay gets MEM/WB
    tbl[11] = mk(1,  0,  0, 1, 0, 14,  1, 0, 0,   0, 0, 0); // producer r14
    tbl[12] = mk(1,  0, 14, 0, 1, 15,  1, 0, 0,   0, 0, 3); // immediate override
    tbl[13] = mk(1,  0,  0, 1, 0,  0,  1, 0, 0,   0, 0, 0); // writes r0
    tbl[14] = mk(1,  0,  0, 1, 0, 16,  1, 0, 0,   0, 0, 0); // r0 never forwards
    tbl[15] = mk(1,  0,  0, 1, 0, 17,  1, 1, 0,   0, 0, 0); // load r17
    tbl[16] = mk(1, 17, 17, 1, 0, 18,  1, 0, 1,   0, 0, 0); // flush beats hazard
    tbl[17] = mk(1, 17,  0, 0, 0, 19,  1, 0, 0,   0, 2, 0); // load now in MEM
    tbl[18] = mk(0, 19,  0, 0, 0, 20,  1, 0, 0,   0, 0, 0); // invalid ID -> bubble

    drive(mk(1, 3, 3, 1, 0, 3, 1, 1, 0, 0, 0, 0));
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_fwd_a", int'(fwd_a), 0);
    check("reset_fwd_b", int'(fwd_b), 0);
    check("reset_stall", int'(stall), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], s_o, a_o, b_o, c_o);
      check($sformatf("tbl%0d_stall", i), int'(s_o), int'(tbl[i].es));
      check($sformatf("tbl%0d_fwd_a", i), int'(a_o), int'(tbl[i].ea));
      check($sformatf("tbl%0d_fwd_b", i), int'(b_o), int'(tbl[i].eb));
      check($sformatf("tbl%0d_cnt", i), c_o, exp_cnt());
    end

    // Mid-operation reset with a load-use hazard pending.
    apply(mk(1, 0, 0, 1, 0, 20, 1, 0, 0, 0, 0, 0), s_o, a_o, b_o, c_o);
    apply(mk(1, 20, 0, 1, 0, 21, 1, 1, 0, 0, 0, 0), s_o, a_o, b_o, c_o);
    check("midrst_pre_fwd_a", int'(a_o), 1);
    drive(mk(1, 21, 20, 1, 0, 22, 1, 0, 0, 0, 0, 0));
    #1;
    check("midrst_pre_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_stall", int'(stall), 0);
    check("midrst_fwd_a", int'(fwd_a), 0);
    check("midrst_fwd_b", int'(fwd_b), 0);
    check("midrst_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 21, 20, 1, 0, 22, 1, 0, 0, 0, 0, 0), s_o, a_o, b_o, c_o);
    check("postrst_stall", int'(s_o), 0);
    check("postrst_fwd_a", int'(a_o), 0);
    check("postrst_fwd_b", int'(b_o), 0);

    // Random traffic on a small register window so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      rv.v    = ($urandom_range(0, 9) != 0);
      rv.rs   = 5'($urandom_range(0, 7));
      rv.rt   = 5'($urandom_range(0, 7));
      rv.urt  = 1'($urandom_range(0, 1));
      rv.imm  = ($urandom_range(0, 4) == 0);
      rv.dest = 5'($urandom_range(0, 7));
      rv.mr   = ($urandom_range(0, 2) == 0);
      rv.rw   = rv.mr ? 1'b1 : 1'($urandom_range(0, 1));
      rv.fl   = ($urandom_range(0, 7) == 0);
      rv.es   = 1'b0;
      rv.ea   = 2'd0;
      rv.eb   = 2'd0;
      apply(rv, s_o, a_o, b_o, c_o);
      check($sformatf("rnd%0d_stall", n), int'(s_o), int'(m_stall));
      check($sformatf("rnd%0d_fwd_a", n), int'(a_o), m_a);
      check($sformatf("rnd%0d_fwd_b", n), int'(b_o), m_b);
      check($sformatf("rnd%0d_cnt", n), c_o, exp_cnt());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks the destination-register state of the instructions in EX and MEM internally.
- Produces registered 2-bit selects that drive the two MUX4x1 operand muxes (A and B) at the ALU input in EX.
- Raises a load-use stall toward the IF/ID registers.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, width of the stall counter (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_uses_rt  in  1  the ID instruction reads rt.
- id_use_imm  in  1  operand B is the immediate.
- id_dest  in  REG_AW  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes the register file.
- id_memread  in  1  the ID instruction is a load.
- flush  in  1  branch taken; kill the ID instruction.
- fwd_a  out  2  oper for the operand-A MUX4x1; valid during EX.
- fwd_b  out  2  oper for the operand-B MUX4x1; valid during EX.
- stall  out  1  hold PC and IF/ID; combinational.
- stall_cnt  out  CNT_W  stall-cycle count.

Behaviour:
- Select encoding: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB result, 3 = immediate. Operand A never takes 3.
- Internal entries E (instruction in EX) and M (instruction in MEM). Each holds valid, dest, regwrite, memread.
- Reset (async, rst_n=0): E and M invalid; fwd_a=0, fwd_b=0; stall_cnt=0. stall=0 follows from the invalid entries.
- stall = id_valid & !flush & E.valid & E.memread & E.dest!=0 & (E.dest==id_rs | (id_uses_rt & E.dest==id_rt)).
- Each rising edge: M <= E.
  - E <= ID fields when id_valid & !stall & !flush.
  - Otherwise E <= bubble (valid=0).
- Select computation, per source s (rs for A; rt for B), latched into fwd_a/fwd_b on the same edge that loads E:
  - 1 if E.valid & E.regwrite & E.dest!=0 & E.dest==s (this instruction becomes EX/MEM).
  - else 2 if M.valid & M.regwrite & M.dest!=0 & M.dest==s (becomes MEM/WB).
  - else 0.
- fwd_b is forced to 3 when id_use_imm, regardless of any match.
- When a bubble is loaded (stall, flush or !id_valid), fwd_a and fwd_b load 0.
- Latency: selects appear one cycle after the instruction is presented in ID, aligned with its EX cycle.
- Load-use: the stall lasts exactly one cycle. On the next cycle the load sits in M, so the dependent instruction gets select 2.
- Simultaneous flush and hazard: flush wins; stall=0; a bubble enters EX.
- Register 0 never forwards, even with regwrite=1.
- Both sources matching the same producer: both selects get the same code.
- WB-stage writes are not forwarded; the register file performs write-before-read.
- Reset mid-operation: all entries are invalidated immediately; no stall is pending after release.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: stall_cnt increments on every edge where stall=1, saturates at all-ones, and clears only on reset.
- Undefined: the counter is not built and stall_cnt is tied to 0. The port list is unchanged.

Decomposition:
- Package fwd_pkg:
  - Select constants FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2, FWD_IMM=2'd3.
  - Stage-entry typedef (valid, dest, regwrite, memread).
- One sub-module, fwd_src_cmp: combinational priority compare of one source register against E and M, returning the 2-bit select.
  - Instantiated twice (A and B).
  - Immediate override and bubble gating stay in the parent.

Test Plan:
- ALU chain: add r3 (regwrite, dest=3) then a consumer with rs=3, rt=4 -> fwd_a=1, fwd_b=0 in the consumer's EX cycle; stall stays 0.
- Distance-2 producer: dest=5, an unrelated instruction, then a consumer with rt=5, id_uses_rt=1 -> fwd_b=2.
- Priority: producers with dest=7 in both M and E, consumer rs=7 -> fwd_a=1 (youngest wins).
- Load-use: load dest=8 then a consumer with rs=8 -> stall=1 for exactly one cycle, a bubble enters EX (fwd_a=0 that cycle), then fwd_a=2. With FWD_STALL_CNT_EN, stall_cnt goes 0->1.
- Immediate and r0: consumer with id_use_imm=1 and rt matching E -> fwd_b=3. Producer with dest=0 -> fwd_a=0.
- Flush during hazard and mid-op reset:
  - flush=1 with a load-use condition present -> stall=0 and the next fwd_a/fwd_b are 0.
  - rst_n pulsed low while E is valid -> outputs and stall_cnt read 0 at once, and no forwarding occurs on the first instruction after release.
